// File: rtl/dma_channel_regfile.sv
// dma_channel_regfile: NCH-channel DMA address/count register file.
// Host access is 8-bit wide through a byte pointer shared by all channels.
module dma_channel_regfile #(
  parameter int NCH = 4,
  parameter int AW  = 16,
  parameter int CW  = 16,
  parameter int CHW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           CLK,
  input  logic           RESET_N,
  input  logic           CS_N,
  input  logic           IOR_N,
  input  logic           IOW_N,
  input  logic [3:0]     A,
  input  logic [CHW-1:0] CH_SEL,
  input  logic [7:0]     DB_IN,
  output logic [7:0]     DB_OUT,
  input  logic           PROG_EN,
  input  logic           STEP,
  input  logic [CHW-1:0] STEP_CH,
  output logic [AW-1:0]  DMA_ADDR,
  output logic [1:0]     XFER_TYPE,
  output logic           TC,
  output logic [NCH-1:0] MASK,
  output logic [NCH-1:0] SW_REQ
);
  localparam logic [2:0] AB = 3'(AW / 8);
  localparam logic [2:0] CB = 3'(CW / 8);

  logic [AW-1:0]  ba_q [NCH], ba_d [NCH];
  logic [AW-1:0]  ca_q [NCH], ca_d [NCH];
  logic [CW-1:0]  bc_q [NCH], bc_d [NCH];
  logic [CW-1:0]  cc_q [NCH], cc_d [NCH];
  logic [7:0]     md_q [NCH], md_d [NCH];
  logic           dis_q, dis_d;
  logic [NCH-1:0] tcf_q, tcf_d;
  logic [NCH-1:0] req_q, req_d;
  logic [NCH-1:0] mask_q, mask_d;
  logic [2:0]     bp_q, bp_d;
  logic           tc_q, tc_d;
  logic           ior_q, iow_q;

  logic           wr, rd_rel, step_go;
  logic [2:0]     nb, bidx, bnext;
  logic [AW-1:0]  na;
  logic [CW-1:0]  nc;
  logic [7:0]     status;

  assign wr      = !CS_N && PROG_EN && !IOW_N && iow_q;
  assign rd_rel  = !CS_N && IOR_N && !ior_q;
  assign step_go = STEP && !dis_q;

  // Out-of-range pointer restarts the access at byte 0.
  always_comb begin
    nb    = (A == 4'd1) ? CB : AB;
    bidx  = (bp_q >= nb) ? 3'd0 : bp_q;
    bnext = (bidx + 3'd1 == nb) ? 3'd0 : bidx + 3'd1;
  end

  always_comb begin
    status = '0;
    for (int i = 0; i < NCH; i++) begin
      status[i]     = tcf_q[i];
      status[4 + i] = req_q[i];
    end
  end

  always_comb begin
    DB_OUT = '0;
    if (!CS_N && !IOR_N) begin
      case (A)
        4'd0:
          for (int b = 0; b < AW / 8; b++)
            if (3'(b) == bidx) DB_OUT = ca_q[CH_SEL][8*b +: 8];
        4'd1:
          for (int b = 0; b < CW / 8; b++)
            if (3'(b) == bidx) DB_OUT = cc_q[CH_SEL][8*b +: 8];
        4'd2:    DB_OUT = md_q[CH_SEL];
        4'd3:    DB_OUT = status;
        default: DB_OUT = '0;
      endcase
    end
  end

  always_comb begin
    ba_d   = ba_q;
    ca_d   = ca_q;
    bc_d   = bc_q;
    cc_d   = cc_q;
    md_d   = md_q;
    dis_d  = dis_q;
    tcf_d  = tcf_q;
    req_d  = req_q;
    mask_d = mask_q;
    bp_d   = bp_q;
    tc_d   = 1'b0;
    na     = '0;
    nc     = '0;
    // Clear first so a terminal count in the same cycle survives.
    if (rd_rel && A == 4'd3) tcf_d = '0;
    if (step_go) begin
      na = md_q[STEP_CH][0] ? ca_q[STEP_CH] - AW'(1)
                            : ca_q[STEP_CH] + AW'(1);
      nc = cc_q[STEP_CH] - CW'(1);
      if (cc_q[STEP_CH] == '0) begin
        tc_d           = 1'b1;
        tcf_d[STEP_CH] = 1'b1;
        req_d[STEP_CH] = 1'b0;
        if (md_q[STEP_CH][1]) begin
          na = ba_q[STEP_CH];
          nc = bc_q[STEP_CH];
        end else begin
          mask_d[STEP_CH] = 1'b1;
        end
      end
      if (!(wr && A == 4'd0 && CH_SEL == STEP_CH)) ca_d[STEP_CH] = na;
      if (!(wr && A == 4'd1 && CH_SEL == STEP_CH)) cc_d[STEP_CH] = nc;
    end
    if (wr) begin
      case (A)
        4'd0:
          for (int b = 0; b < AW / 8; b++)
            if (3'(b) == bidx) begin
              ba_d[CH_SEL][8*b +: 8] = DB_IN;
              ca_d[CH_SEL][8*b +: 8] = DB_IN;
            end
        4'd1:
          for (int b = 0; b < CW / 8; b++)
            if (3'(b) == bidx) begin
              bc_d[CH_SEL][8*b +: 8] = DB_IN;
              cc_d[CH_SEL][8*b +: 8] = DB_IN;
            end
        4'd2:    md_d[CH_SEL]   = DB_IN;
        4'd3:    dis_d          = DB_IN[0];
        4'd4:    req_d[CH_SEL]  = DB_IN[0];
        4'd5:    mask_d[CH_SEL] = DB_IN[0];
        4'd6:    mask_d         = DB_IN[NCH-1:0];
        4'd7:    bp_d           = '0;
        default: ;
      endcase
    end
    if ((wr || rd_rel) && (A == 4'd0 || A == 4'd1)) bp_d = bnext;
    if (wr && A == 4'd8) begin
      ba_d   = '{default: '0};
      ca_d   = '{default: '0};
      bc_d   = '{default: '0};
      cc_d   = '{default: '0};
      md_d   = '{default: '0};
      dis_d  = 1'b0;
      tcf_d  = '0;
      req_d  = '0;
      mask_d = '1;
      bp_d   = '0;
      tc_d   = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      ba_q   <= '{default: '0};
      ca_q   <= '{default: '0};
      bc_q   <= '{default: '0};
      cc_q   <= '{default: '0};
      md_q   <= '{default: '0};
      dis_q  <= 1'b0;
      tcf_q  <= '0;
      req_q  <= '0;
      mask_q <= '1;
      bp_q   <= '0;
      tc_q   <= 1'b0;
      ior_q  <= 1'b1;
      iow_q  <= 1'b1;
    end else begin
      ba_q   <= ba_d;
      ca_q   <= ca_d;
      bc_q   <= bc_d;
      cc_q   <= cc_d;
      md_q   <= md_d;
      dis_q  <= dis_d;
      tcf_q  <= tcf_d;
      req_q  <= req_d;
      mask_q <= mask_d;
      bp_q   <= bp_d;
      tc_q   <= tc_d;
      ior_q  <= IOR_N;
      iow_q  <= IOW_N;
    end
  end

  assign DMA_ADDR  = ca_q[STEP_CH];
  assign XFER_TYPE = md_q[STEP_CH][3:2];
  assign TC        = tc_q;
  assign MASK      = mask_q;
  assign SW_REQ    = req_q;
endmodule
